// File: rtl/input_filter_pkg.sv
// input_filter_pkg: shared defaults and counter bound for the input filter
package input_filter_pkg;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_WIDTH = 2;
  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction
endpackage

// File: rtl/input_filter_if.sv
// input_filter_if: raw lines and filter_en in; stable_out, rise, fall, changed out
interface input_filter_if import input_filter_pkg::*; #(
  parameter int CHANNELS = DEF_CHANNELS
);
  logic [CHANNELS-1:0] in;
  logic filter_en;
  logic [CHANNELS-1:0] stable_out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic changed;
  modport master (output in, filter_en, input stable_out, rise, fall, changed);
  modport slave (input in, filter_en, output stable_out, rise, fall, changed);
endinterface

// File: rtl/input_filter_channel.sv
// input_filter_channel: one line: synchroniser, saturating counter, level and edge pulses
// ports: clk, reset, in, filter_en -> stable_out, rise, fall, toggle (unregistered next edge)
module input_filter_channel import input_filter_pkg::*; #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic filter_en,
  output logic stable_out,
  output logic rise,
  output logic fall,
  output logic toggle
);
  localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic sync, next_stable;
  assign sync = sync_q[SYNC_STAGES-1];
  // level decisions use the pre-update count; bypass preloads the count so filtering resumes cleanly
  always_comb begin
    next_stable = filter_en ? (cnt == MAX ? 1'b1 : cnt == '0 ? 1'b0 : stable_out) : sync;
    cnt_next = !filter_en ? (sync ? MAX : '0)
             : sync ? (cnt == MAX ? cnt : cnt + CNT_WIDTH'(1))
             : (cnt == '0 ? cnt : cnt - CNT_WIDTH'(1));
  end
  assign toggle = next_stable ^ stable_out;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt <= '0;
      stable_out <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      cnt <= cnt_next;
      stable_out <= next_stable;
      rise <= next_stable & ~stable_out;
      fall <= ~next_stable & stable_out;
    end
  end
endmodule

// File: rtl/input_filter.sv
// input_filter: CHANNELS independent debounced inputs with edge pulses and a global changed flag
// ports: clk, reset (sync, active-high), bus (slave: in, filter_en -> stable_out, rise, fall, changed)
module input_filter import input_filter_pkg::*; #(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic clk,
  input logic reset,
  input_filter_if.slave bus
);
  logic [CHANNELS-1:0] toggle;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_filter_channel #(.SYNC_STAGES(SYNC_STAGES), .CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk(clk),
      .reset(reset),
      .in(bus.in[i]),
      .filter_en(bus.filter_en),
      .stable_out(bus.stable_out[i]),
      .rise(bus.rise[i]),
      .fall(bus.fall[i]),
      .toggle(toggle[i])
    );
  end
  // toggle is the next rise|fall, so changed lands in the same cycle as the pulses
  always_ff @(posedge clk) bus.changed <= reset ? 1'b0 : |toggle;
endmodule

// File: tb/tb_input_filter.sv
// tb_input_filter: vector-table scoreboard on the default build plus latency/glitch sequences on a wide build
module tb_input_filter;
  typedef struct {
    logic rst;
    logic en;
    logic [3:0] din;
    logic [3:0] st;
    logic [3:0] ri;
    logic [3:0] fa;
    logic ch;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  input_filter_if #(.CHANNELS(4)) bus();
  input_filter_if #(.CHANNELS(4)) bus3();
  input_filter dut (.clk(clk), .reset(reset), .bus(bus));
  input_filter #(.CHANNELS(4), .SYNC_STAGES(3), .CNT_WIDTH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  always #5 clk = ~clk;
  function automatic vec_t v(logic rst, logic en, logic [3:0] din, logic [3:0] st, logic [3:0] ri, logic [3:0] fa, logic ch);
    vec_t x;
    x.rst = rst;
    x.en = en;
    x.din = din;
    x.st = st;
    x.ri = ri;
    x.fa = fa;
    x.ch = ch;
    return x;
  endfunction
  task automatic add(input int n, input vec_t x);
    repeat (n) tbl.push_back(x);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic measure(input logic lvl, output int lat);
    @(negedge clk);
    bus3.in = {3'b000, lvl};
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus3.stable_out[0] === lvl) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic pulse3(input int len, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus3.in = {3'b000, k < len};
      @(posedge clk);
      #1;
      seen |= bus3.stable_out[0];
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t e;
    int lat;
    logic seen;
    bus.in = '0;
    bus.filter_en = 1'b1;
    bus3.in = '0;
    bus3.filter_en = 1'b1;
    // reset, then channel 0 held high: rise after 6 edges
    add(2, v(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    add(5, v(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 1));
    add(2, v(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0));
    // all channels high, then all fall together
    add(5, v(0, 1, 4'hf, 4'h1, 4'h0, 4'h0, 0));
    add(1, v(0, 1, 4'hf, 4'hf, 4'he, 4'h0, 1));
    add(1, v(0, 1, 4'hf, 4'hf, 4'h0, 4'h0, 0));
    add(5, v(0, 1, 4'h0, 4'hf, 4'h0, 4'h0, 0));
    add(1, v(0, 1, 4'h0, 4'h0, 4'h0, 4'hf, 1));
    add(1, v(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    // channel 1: 2-cycle pulse rejected, 3-cycle pulse accepted
    add(2, v(0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 0));
    add(6, v(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    add(3, v(0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 0));
    add(2, v(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(0, 1, 4'h0, 4'h2, 4'h2, 4'h0, 1));
    add(2, v(0, 1, 4'h0, 4'h2, 4'h0, 4'h0, 0));
    add(1, v(0, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1));
    add(1, v(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    // bypass: 1-cycle glitch on channel 2 passes through
    add(2, v(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(0, 0, 4'h4, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(0, 0, 4'h0, 4'h4, 4'h4, 4'h0, 1));
    add(1, v(0, 0, 4'h0, 4'h0, 4'h0, 4'h4, 1));
    add(2, v(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    // channel 3: reset at count 2 discards progress, full latency restarts
    add(4, v(0, 1, 4'h8, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(1, 1, 4'h8, 4'h0, 4'h0, 4'h0, 0));
    add(5, v(0, 1, 4'h8, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(0, 1, 4'h8, 4'h8, 4'h8, 4'h0, 1));
    add(1, v(0, 1, 4'h8, 4'h8, 4'h0, 4'h0, 0));
    // bypass drop and rise on channel 3, then resume filtering with no spurious edge
    add(2, v(0, 0, 4'h0, 4'h8, 4'h0, 4'h0, 0));
    add(1, v(0, 0, 4'h0, 4'h0, 4'h0, 4'h8, 1));
    add(1, v(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    add(2, v(0, 0, 4'h8, 4'h0, 4'h0, 4'h0, 0));
    add(1, v(0, 0, 4'h8, 4'h8, 4'h8, 4'h0, 1));
    add(1, v(0, 0, 4'h8, 4'h8, 4'h0, 4'h0, 0));
    add(3, v(0, 1, 4'h8, 4'h8, 4'h0, 4'h0, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      bus.filter_en = tbl[i].en;
      bus.in = tbl[i].din;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d stable_out", i), 32'(bus.stable_out), 32'(e.st));
      chk($sformatf("row%0d rise", i), 32'(bus.rise), 32'(e.ri));
      chk($sformatf("row%0d fall", i), 32'(bus.fall), 32'(e.fa));
      chk($sformatf("row%0d changed", i), 32'(bus.changed), 32'(e.ch));
    end
    // wide build: latency 3+7+1 both ways, 6-cycle glitch rejected, 7-cycle accepted
    measure(1'b1, lat);
    chk("w3 rise latency", 32'(lat), 32'd11);
    chk("w3 rise pulse", 32'(bus3.rise), 32'h1);
    chk("w3 changed", 32'(bus3.changed), 32'h1);
    measure(1'b0, lat);
    chk("w3 fall latency", 32'(lat), 32'd11);
    chk("w3 fall pulse", 32'(bus3.fall), 32'h1);
    repeat (12) @(negedge clk);
    pulse3(6, seen);
    chk("w3 glitch6 rejected", 32'(seen), 32'h0);
    pulse3(7, seen);
    chk("w3 pulse7 accepted", 32'(seen), 32'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/input_filter.md
INPUT_FILTER -- requirements
Module: input_filter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input lines.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, legal range 2..4.
REQ-003 SHALL have parameter CNT_WIDTH, default 2: filter counter width, legal range 1..8; MAX = 2^CNT_WIDTH-1.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in, input, CHANNELS: asynchronous raw lines, bit i is channel i.
REQ-007 SHALL have port filter_en, input, 1: 1 = filtering active, 0 = bypass (synchronise only).
REQ-008 SHALL have port stable_out, output, CHANNELS: registered filtered level per channel.
REQ-009 SHALL have port rise, output, CHANNELS: one-cycle registered pulse on a 0->1 change of stable_out[i].
REQ-010 SHALL have port fall, output, CHANNELS: one-cycle registered pulse on a 1->0 change of stable_out[i].
REQ-011 SHALL have port changed, output, 1: registered OR of all rise and fall bits of the same cycle.

Function
REQ-012 Each channel SHALL pass in[i] through SYNC_STAGES flops; sync[i] is the last-stage output.
REQ-013 With filter_en=1, cnt[i] SHALL increment by 1 when sync[i]=1 and cnt[i]<MAX, decrement by 1 when sync[i]=0 and cnt[i]>0, and hold otherwise (saturating, never wraps).
REQ-014 With filter_en=1, the next stable_out[i] SHALL be 1 when the pre-update cnt[i]==MAX, 0 when the pre-update cnt[i]==0, and the hold value otherwise.
REQ-015 Latency SHALL be exactly SYNC_STAGES+MAX+1 edges from the first edge that samples a clean step at in[i] (counter starting at the opposite bound) to the edge that updates stable_out[i]; this is 6 edges at the defaults.
REQ-016 A high or low pulse lasting fewer than MAX sync cycles SHALL NOT change stable_out[i].
REQ-017 With filter_en=0, the next stable_out[i] SHALL equal sync[i] (latency SYNC_STAGES+1), and cnt[i] SHALL be loaded with MAX when sync[i]=1 and 0 otherwise.
REQ-018 When filter_en goes 0->1, filtering SHALL resume from the loaded counter with no spurious stable_out change.
REQ-019 rise[i] SHALL equal next_stable & ~stable_out[i] registered, and fall[i] SHALL equal ~next_stable & stable_out[i] registered; each is high only in the cycle stable_out[i] takes its new value.
REQ-020 rise[i] and fall[i] SHALL never be high in the same cycle.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses.
REQ-022 changed SHALL be asserted in the same cycle as any rise or fall bit.

Reset
REQ-023 While reset=1 at an edge, the sync flops, cnt, stable_out, rise, fall and changed SHALL all be cleared to 0.
REQ-024 Reset SHALL take priority over filter_en and in; a reset asserted mid-count SHALL discard the partial count, with no rise or fall pulse.
REQ-025 After reset is released, the first edge SHALL behave as a normal update from the all-zero state.

Structure
REQ-026 Default parameter values and the MAX computation SHALL be defined in the shared package input_filter_pkg.
REQ-027 The per-channel logic (synchroniser, counter, level and pulse registers) SHALL be the sub-module input_filter_channel, instantiated CHANNELS times by generate.
REQ-028 The top level SHALL contain only the generate loop and the changed OR-reduction register.

Verification
REQ-029 Defaults, reset, then in=4'b0001 held: stable_out[0]=1 and rise[0]=1 at edge 6 after the first sampling edge; rise[0]=0 at edge 7; other channels stay 0.
REQ-030 Defaults, in[1] high pulse of 2 cycles, then a pulse of 3 cycles: the first gives no output change; the second sets stable_out[1]=1 at the expected edge.
REQ-031 filter_en=0, 1-cycle glitch on in[2]: stable_out[2] high for exactly 1 cycle, starting 3 edges after the glitch is sampled; rise[2] and fall[2] both pulse, one cycle apart.
REQ-032 stable_out=4'b1111, then in=4'b0000 on all channels at once: fall=4'b1111 for one cycle and changed=1 for that cycle only.
REQ-033 Reset asserted when cnt[3]=2 during a rising step: the next edge gives cnt[3]=0 and stable_out=0 with no pulses; after release, the full latency restarts.
REQ-034 CNT_WIDTH=3, SYNC_STAGES=3: a held step gives latency 3+7+1=11 edges, and a 6-cycle glitch is rejected.
